// File: rtl/hsid_sq_diff_acc.sv
// Sum of squared differences over band_count paired pops from the test and
// reference FIFOs; result offered on a valid/ready handshake.
module hsid_sq_diff_acc #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BAND_CNT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH      = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      start,
    input  logic [BAND_CNT_WIDTH-1:0] band_count,
    input  logic                      vctr_empty,
    input  logic                      ref_empty,
    output logic                      vctr_rd_en,
    output logic                      ref_rd_en,
    input  logic [DATA_WIDTH-1:0]     vctr_data,
    input  logic [DATA_WIDTH-1:0]     ref_data,
    output logic                      busy,
    output logic [ACC_WIDTH-1:0]      result,
    output logic                      result_valid,
    input  logic                      result_ready
);

    localparam int unsigned SQ_WIDTH = 2 * DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      state;
    logic [BAND_CNT_WIDTH-1:0]   bands;
    logic [BAND_CNT_WIDTH-1:0]   issued;
    logic [BAND_CNT_WIDTH-1:0]   returned;
    logic                        pair_v;
    logic                        diff_v;
    logic signed [DATA_WIDTH:0]  diff;
    logic signed [SQ_WIDTH-1:0]  diff_ext;
    logic signed [SQ_WIDTH-1:0]  sq;
    logic [ACC_WIDTH:0]          sum;
    logic [ACC_WIDTH-1:0]        acc;
    logic [ACC_WIDTH-1:0]        acc_next;
    logic                        rd;

    assign rd         = (state == READ) && !clear && !vctr_empty && !ref_empty
                        && (issued < bands);
    assign vctr_rd_en = rd;
    assign ref_rd_en  = rd;
    assign busy       = (state != IDLE);
    assign result     = acc;

    // Carry out of the widened sum selects the all-ones clamp.
    always_comb begin
        diff_ext = SQ_WIDTH'(diff);
        sq       = diff_ext * diff_ext;
        sum      = {1'b0, acc} + (ACC_WIDTH + 1)'($unsigned(sq));
        acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bands        <= '0;
            issued       <= '0;
            returned     <= '0;
            pair_v       <= 1'b0;
            diff_v       <= 1'b0;
            diff         <= '0;
            acc          <= '0;
            result_valid <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            issued       <= '0;
            returned     <= '0;
            pair_v       <= 1'b0;
            diff_v       <= 1'b0;
            acc          <= '0;
            result_valid <= 1'b0;
        end else begin
            pair_v <= rd;
            diff_v <= pair_v;
            if (pair_v)
                diff <= $signed({1'b0, vctr_data}) - $signed({1'b0, ref_data});
            if (diff_v) begin
                acc      <= acc_next;
                returned <= returned + BAND_CNT_WIDTH'(1);
            end
            if (rd)
                issued <= issued + BAND_CNT_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        bands    <= band_count;
                        acc      <= '0;
                        issued   <= '0;
                        returned <= '0;
                        if (band_count == '0) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (issued == bands)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Leave on the same edge the final square is accumulated.
                    if (diff_v && (returned + BAND_CNT_WIDTH'(1) == bands)) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsid_sq_diff_acc.sv
// Directed bench for hsid_sq_diff_acc with behavioural models of the test
// and reference FIFOs (1-cycle read latency).
module tb_hsid_sq_diff_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [7:0]  band_count;
    logic        vctr_empty;
    logic        ref_empty;
    logic        vctr_rd_en;
    logic        ref_rd_en;
    logic [15:0] vctr_data = '0;
    logic [15:0] ref_data = '0;
    logic        busy;
    logic [39:0] result;
    logic        result_valid;
    logic        result_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] vmem [0:511];
    logic [15:0] rmem [0:511];
    int vwr = 0, vrd = 0, rwr = 0, rrd = 0;
    int pops = 0, bad_pops = 0, stall_at = 0, hold_cnt = 0;
    logic vhold = 1'b0;

    always #5 clk = ~clk;

    hsid_sq_diff_acc #(
        .DATA_WIDTH     (16),
        .BAND_CNT_WIDTH (8),
        .ACC_WIDTH      (40)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .start        (start),
        .band_count   (band_count),
        .vctr_empty   (vctr_empty),
        .ref_empty    (ref_empty),
        .vctr_rd_en   (vctr_rd_en),
        .ref_rd_en    (ref_rd_en),
        .vctr_data    (vctr_data),
        .ref_data     (ref_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    assign vctr_empty = vhold || (vwr == vrd);
    assign ref_empty  = (rwr == rrd);

    // FIFO models; the test FIFO can be forced empty for 3 cycles after pop #stall_at.
    always @(posedge clk) begin
        if (vctr_rd_en !== ref_rd_en)
            bad_pops <= bad_pops + 1;
        else if (vctr_rd_en && (vctr_empty || ref_empty))
            bad_pops <= bad_pops + 1;
        if (vctr_rd_en) begin
            vctr_data <= vmem[vrd % 512];
            vrd       <= vrd + 1;
            pops      <= pops + 1;
            if (pops + 1 == stall_at) begin
                vhold    <= 1'b1;
                hold_cnt <= 3;
            end
        end
        if (ref_rd_en) begin
            ref_data <= rmem[rrd % 512];
            rrd      <= rrd + 1;
        end
        if (vhold) begin
            if (hold_cnt == 1)
                vhold <= 1'b0;
            hold_cnt <= hold_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] v, input logic [15:0] r);
        vmem[vwr % 512] = v;
        rmem[rwr % 512] = r;
        vwr++;
        rwr++;
    endtask

    task automatic flush();
        vwr = vrd;
        rwr = rrd;
    endtask

    task automatic start_vec(input int n);
        band_count = 8'(n);
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    // Edges after the start-sampling edge until result_valid is seen.
    task automatic wait_valid(input int bound, output int lat);
        lat = 0;
        while (!result_valid && lat < bound) begin
            step(1);
            lat++;
        end
    endtask

    int p0;
    int lat;
    logic [63:0] exp_t2;

    initial begin
        rst_n        = 1'b1;
        clear        = 1'b0;
        start        = 1'b0;
        band_count   = '0;
        result_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_vrd", vctr_rd_en, 0);
        check("rst_rrd", ref_rd_en, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // T1 basic
        push(10, 12); push(20, 18); push(30, 30); push(40, 45);
        p0 = pops;
        start_vec(4);
        check("t1_busy", busy, 1);
        wait_valid(20, lat);
        check("t1_latency", lat, 6);
        check("t1_result", result, 33);
        check("t1_pops", pops - p0, 4);
        step(1);
        check("t1_valid_drop", result_valid, 0);
        check("t1_idle", busy, 0);

        // T2 extremes
        for (int i = 0; i < 255; i++) push(16'hFFFF, 16'h0000);
        exp_t2 = 64'd255 * 64'd65535 * 64'd65535;
        p0 = pops;
        start_vec(255);
        wait_valid(300, lat);
        check("t2_latency", lat, 257);
        check("t2_result", result, exp_t2);
        check("t2_pops", pops - p0, 255);
        step(1);

        // T3 stall: diffs 10,-5,0,65535,-5,0,10,-1
        push(100, 90); push(0, 5); push(7, 7); push(65535, 0);
        push(3, 8); push(9, 9); push(50, 40); push(1, 2);
        p0 = pops;
        stall_at = pops + 2;
        start_vec(8);
        wait_valid(40, lat);
        stall_at = 0;
        check("t3_latency", lat, 13);
        check("t3_result", result, 64'd4294836476);
        check("t3_pops", pops - p0, 8);
        check("t3_bad_pops", bad_pops, 0);
        step(1);

        // T4 zero length
        p0 = pops;
        start_vec(0);
        check("t4_valid", result_valid, 1);
        check("t4_result", result, 0);
        step(1);
        check("t4_valid_drop", result_valid, 0);
        check("t4_pops", pops - p0, 0);

        // T5 abort after 3 of 6 pops, then a fresh vector
        for (int i = 1; i <= 6; i++) push(16'(i * 100), 16'(i));
        p0 = pops;
        start_vec(6);
        step(3);
        clear = 1'b1;
        #1;
        check("t5_vrd_clear", vctr_rd_en, 0);
        check("t5_rrd_clear", ref_rd_en, 0);
        step(1);
        clear = 1'b0;
        check("t5_idle", busy, 0);
        check("t5_valid", result_valid, 0);
        check("t5_acc_zero", result, 0);
        step(3);
        check("t5_no_residue", result, 0);
        check("t5_pops", pops - p0, 3);
        flush();
        push(3, 1); push(7, 10);
        start_vec(2);
        wait_valid(20, lat);
        check("t5_new_latency", lat, 4);
        check("t5_new_result", result, 13);
        step(1);

        // T6 backpressure with start pulsed during DONE
        result_ready = 1'b0;
        push(5, 0); push(5, 0); push(5, 0); push(9, 1);
        p0 = pops;
        start_vec(3);
        wait_valid(20, lat);
        check("t6_latency", lat, 5);
        check("t6_result", result, 75);
        band_count = 8'd1;
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 2);
            step(1);
            check("t6_hold_result", result, 75);
            check("t6_hold_valid", result_valid, 1);
        end
        start = 1'b0;
        result_ready = 1'b1;
        step(1);
        check("t6_release_valid", result_valid, 0);
        check("t6_release_idle", busy, 0);
        step(2);
        check("t6_start_ignored", busy, 0);
        check("t6_pops", pops - p0, 3);
        flush();

        // Asynchronous reset mid-vector
        push(1, 2); push(3, 4); push(5, 6); push(7, 8);
        start_vec(4);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rd", vctr_rd_en, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_valid", result_valid, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("final_bad_pops", bad_pops, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
